vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two requesters.
  - Video fetch port: driven from the scaled hpos/vpos scan logic.
  - CPU port: driven by the CPU core inside the chip.
- Runs in the masterclk domain. Video has default priority; a bounded-wait counter guarantees CPU forward progress.
- Registers all RAM control outputs and routes read data back to the requester that issued the read.

---
 rtl/vram_arbiter_if.sv | 41 ++++
 rtl/vram_arbiter.sv | 77 +++++++
 tb/tb_vram_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the RAM macro.
// The slave modport is the arbiter's view; master is everything around it.
interface vram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_stall;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vid_gnt, vid_rvalid, vid_rdata, vid_stall,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vid_gnt, vid_rvalid, vid_rdata, vid_stall,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous VRAM between video fetch and the CPU.
// Video wins by default; a saturating wait counter forces one CPU transfer.
module vram_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 8,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    vram_arbiter_if.slave  bus
);
    logic [3:0] wait_cnt;
    logic       cpu_forced;
    logic       vid_xfer;
    logic       cpu_xfer;
    logic       vid_tag;
    logic       cpu_tag;

    assign cpu_forced = (wait_cnt >= 4'(CPU_MAX_WAIT));

    always_comb begin
        bus.vid_gnt = 1'b0;
        bus.cpu_gnt = 1'b0;
        if (cpu_forced && bus.cpu_req) begin
            bus.cpu_gnt = 1'b1;
        end else if (bus.vid_req) begin
            bus.vid_gnt = 1'b1;
        end else begin
            bus.cpu_gnt = bus.cpu_req;
        end
    end

    assign vid_xfer = bus.vid_req & bus.vid_gnt;
    assign cpu_xfer = bus.cpu_req & bus.cpu_gnt;

    // Read data is a straight passthrough; only the delayed tags qualify it.
    assign bus.vid_rdata = bus.mem_rdata;
    assign bus.cpu_rdata = bus.mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt       <= 4'd0;
            bus.vid_stall  <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            vid_tag        <= 1'b0;
            cpu_tag        <= 1'b0;
            bus.vid_rvalid <= 1'b0;
            bus.cpu_rvalid <= 1'b0;
        end else begin
            if (!bus.cpu_req || cpu_xfer) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != 4'hF) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            bus.vid_stall <= bus.vid_req & cpu_forced & bus.cpu_req;

            bus.mem_en <= vid_xfer | cpu_xfer;
            bus.mem_we <= cpu_xfer & bus.cpu_we;
            if (cpu_xfer) begin
                bus.mem_addr  <= bus.cpu_addr;
                bus.mem_wdata <= bus.cpu_wdata;
            end else if (vid_xfer) begin
                bus.mem_addr  <= bus.vid_addr;
            end

            // Tag travels with the issue, then one more stage to meet the RAM data.
            vid_tag        <= vid_xfer;
            cpu_tag        <= cpu_xfer & ~bus.cpu_we;
            bus.vid_rvalid <= vid_tag;
            bus.cpu_rvalid <= cpu_tag;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a shadow memory predicts read data and
// each accepted read is queued with the cycle its rvalid must appear in.
module tb_vram_arbiter;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    logic clk;
    logic reset;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] ram   [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] model [0:(1<<ADDR_W)-1];
    exp_t vid_q[$];
    exp_t cpu_q[$];
    exp_t ev;
    exp_t ec;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   vid_seen = 0;
    int   cpu_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous single-port RAM: read-first, data valid one cycle after issue.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= ram[bus.mem_addr];
            if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
        end
    end

    // Returns are retired before new handshakes are queued in the same cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.vid_rvalid) begin
                vid_seen++;
                vectors++;
                if (vid_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL vid_rvalid_unexpected: got rvalid at cycle %0d, required none", cyc);
                end else begin
                    ev = vid_q.pop_front();
                    if (bus.vid_rdata !== ev.data || cyc !== ev.due) begin
                        miscompares++;
                        $display("[TB] FAIL vid_return: got data %0h at cycle %0d, required %0h at cycle %0d",
                                 bus.vid_rdata, cyc, ev.data, ev.due);
                    end
                end
            end
            if (bus.cpu_rvalid) begin
                cpu_seen++;
                vectors++;
                if (cpu_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL cpu_rvalid_unexpected: got rvalid at cycle %0d, required none", cyc);
                end else begin
                    ec = cpu_q.pop_front();
                    if (bus.cpu_rdata !== ec.data || cyc !== ec.due) begin
                        miscompares++;
                        $display("[TB] FAIL cpu_return: got data %0h at cycle %0d, required %0h at cycle %0d",
                                 bus.cpu_rdata, cyc, ec.data, ec.due);
                    end
                end
            end
            if (bus.vid_req && bus.vid_gnt)
                vid_q.push_back('{data: model[bus.vid_addr], due: cyc + 2});
            if (bus.cpu_req && bus.cpu_gnt) begin
                if (bus.cpu_we) model[bus.cpu_addr] = bus.cpu_wdata;
                else cpu_q.push_back('{data: model[bus.cpu_addr], due: cyc + 2});
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (vid_q.size() == 0 && cpu_q.size() == 0) break;
        end
    endtask

    task automatic idle_bus;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
    endtask

    task automatic test_reset;
        int base;
        @(negedge clk);
        vectors++;
        if ({bus.mem_en, bus.mem_we, bus.vid_rvalid, bus.cpu_rvalid, bus.vid_stall,
             bus.vid_gnt, bus.cpu_gnt} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b, required 0000000",
                     {bus.mem_en, bus.mem_we, bus.vid_rvalid, bus.cpu_rvalid, bus.vid_stall,
                      bus.vid_gnt, bus.cpu_gnt});
        end
        #2 reset = 1'b1;

        next_cycle();
        bus.vid_req  = 1'b1;
        bus.vid_addr = 13'h0100;
        @(negedge clk);
        vectors++;
        if (bus.vid_gnt !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_pre_gnt: got vid_gnt %b, required 1", bus.vid_gnt);
        end

        next_cycle();
        bus.vid_req = 1'b0;
        #2 reset = 1'b0;
        vid_q.delete();
        cpu_q.delete();
        #1;
        vectors++;
        if ({bus.mem_en, bus.mem_we, bus.vid_rvalid, bus.cpu_rvalid, bus.vid_stall} !== 5'b0 ||
            bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_midread: got flags %b addr %0h wdata %0h, required all 0",
                     {bus.mem_en, bus.mem_we, bus.vid_rvalid, bus.cpu_rvalid, bus.vid_stall},
                     bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        #2 reset = 1'b1;

        base = vid_seen;
        repeat (4) next_cycle();
        vectors++;
        if (vid_seen !== base) begin
            miscompares++;
            $display("[TB] FAIL reset_dropped: got %0d returns after release, required 0", vid_seen - base);
        end

        bus.vid_req  = 1'b1;
        bus.vid_addr = 13'h0100;
        next_cycle();
        bus.vid_req = 1'b0;
        wait_drain();
        vectors++;
        if (vid_seen - base !== 1 || vid_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_reread: got %0d returns, %0d pending, required 1 and 0",
                     vid_seen - base, vid_q.size());
        end
    endtask

    task automatic test_cpu_write_read;
        int vbase;
        int cbase;
        vbase = vid_seen;
        cbase = cpu_seen;
        next_cycle();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 13'h1234;
        bus.cpu_wdata = 8'h5A;
        @(negedge clk);
        vectors++;
        if ({bus.vid_gnt, bus.cpu_gnt} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL cpu_write_gnt: got %b, required 01", {bus.vid_gnt, bus.cpu_gnt});
        end
        next_cycle();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.mem_en, bus.mem_we} !== 2'b11 || bus.mem_addr !== 13'h1234 || bus.mem_wdata !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL cpu_write_issue: got en/we %b addr %0h wdata %0h, required 11 1234 5a",
                     {bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
        end
        next_cycle();
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.vid_gnt, bus.cpu_gnt} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL cpu_read_gnt: got %b, required 01", {bus.vid_gnt, bus.cpu_gnt});
        end
        next_cycle();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.mem_en, bus.mem_we} !== 2'b10 || bus.mem_addr !== 13'h1234) begin
            miscompares++;
            $display("[TB] FAIL cpu_read_issue: got en/we %b addr %0h, required 10 1234",
                     {bus.mem_en, bus.mem_we}, bus.mem_addr);
        end
        wait_drain();
        vectors++;
        if (cpu_seen - cbase !== 1 || vid_seen !== vbase || model[13'h1234] !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL cpu_read_count: got cpu %0d vid %0d, required cpu 1 vid 0",
                     cpu_seen - cbase, vid_seen - vbase);
        end
    endtask

    task automatic test_video_stream;
        int base;
        base = vid_seen;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            bus.vid_req  = 1'b1;
            bus.vid_addr = 13'(i);
            @(negedge clk);
            vectors++;
            if (bus.vid_gnt !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL stream_gnt: got vid_gnt %b at address %0d, required 1", bus.vid_gnt, i);
            end
        end
        next_cycle();
        bus.vid_req = 1'b0;
        wait_drain();
        vectors++;
        if (vid_seen - base !== 10 || vid_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL stream_count: got %0d returns, %0d pending, required 10 and 0",
                     vid_seen - base, vid_q.size());
        end
    endtask

    task automatic test_starvation;
        logic [1:0]        exp_gnt   [7];
        logic              exp_stall [7];
        logic [ADDR_W-1:0] va;
        exp_gnt   = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
        exp_stall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        va = 13'h0500;
        next_cycle();
        bus.vid_req  = 1'b1;
        bus.vid_addr = va;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 13'h0042;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vectors++;
            if ({bus.vid_gnt, bus.cpu_gnt} !== exp_gnt[c] || bus.vid_stall !== exp_stall[c]) begin
                miscompares++;
                $display("[TB] FAIL starve_c%0d: got gnt %b stall %b, required gnt %b stall %b",
                         c, {bus.vid_gnt, bus.cpu_gnt}, bus.vid_stall, exp_gnt[c], exp_stall[c]);
            end
            if (bus.vid_gnt) va = va + 13'd1;
            if (bus.cpu_gnt) begin
                next_cycle();
                bus.cpu_req = 1'b0;
            end else begin
                next_cycle();
            end
            bus.vid_addr = va;
        end
        bus.vid_req = 1'b0;
        wait_drain();
        vectors++;
        if (vid_q.size() + cpu_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL starve_drain: got %0d pending, required 0", vid_q.size() + cpu_q.size());
        end
    endtask

    task automatic test_simultaneous;
        int gc;
        gc = -1;
        next_cycle();
        bus.vid_req  = 1'b1;
        bus.vid_addr = 13'h0600;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 13'h0077;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                vectors++;
                if ({bus.vid_gnt, bus.cpu_gnt} !== 2'b10) begin
                    miscompares++;
                    $display("[TB] FAIL simul_first: got %b, required 10", {bus.vid_gnt, bus.cpu_gnt});
                end
            end
            if (bus.cpu_gnt) begin
                gc = c;
                break;
            end
            next_cycle();
            bus.vid_addr = bus.vid_addr + 13'd1;
            if (c == 1) bus.vid_req = 1'b0;
        end
        vectors++;
        if (gc !== 2) begin
            miscompares++;
            $display("[TB] FAIL simul_cpu_gnt: got cpu grant in cycle %0d, required 2", gc);
        end
        next_cycle();
        idle_bus();
        wait_drain();
        vectors++;
        if (vid_q.size() + cpu_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL simul_drain: got %0d pending, required 0", vid_q.size() + cpu_q.size());
        end
    endtask

    task automatic test_back_to_back_writes;
        int vbase;
        int cbase;
        vbase = vid_seen;
        cbase = cpu_seen;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.vid_req   = 1'b0;
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = 13'h0300 + 13'(k);
            bus.cpu_wdata = 8'hC0 + 8'(k);
            @(negedge clk);
            vectors++;
            if ({bus.vid_gnt, bus.cpu_gnt} !== 2'b01) begin
                miscompares++;
                $display("[TB] FAIL wr_gnt_%0d: got %b, required 01", k, {bus.vid_gnt, bus.cpu_gnt});
            end
            next_cycle();
            bus.cpu_req  = 1'b0;
            bus.vid_req  = 1'b1;
            bus.vid_addr = 13'h0300 + 13'(k);
            @(negedge clk);
            vectors++;
            if ({bus.vid_gnt, bus.cpu_gnt} !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL wr_vid_gnt_%0d: got %b, required 10", k, {bus.vid_gnt, bus.cpu_gnt});
            end
        end
        next_cycle();
        idle_bus();
        wait_drain();
        vectors++;
        if (cpu_seen !== cbase || vid_seen - vbase !== 3 || vid_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL wr_counts: got cpu %0d vid %0d, required cpu 0 vid 3",
                     cpu_seen - cbase, vid_seen - vbase);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion by 100000, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i]   = 8'(i * 7 + 3);
            model[i] = 8'(i * 7 + 3);
        end
        bus.mem_rdata = '0;
        idle_bus();
        reset = 1'b0;
        repeat (2) @(posedge clk);

        test_reset();
        test_cpu_write_read();
        test_video_stream();
        test_starvation();
        test_simultaneous();
        test_back_to_back_writes();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
